// File: rtl/yuv_to_rgb.sv
// yuv_to_rgb: 3-stage BT.601 YUV444 to RGB888 stream converter; define YUV_TO_RGB_STUDIO_RANGE_EN for studio-range input
module yuv_to_rgb #(
  parameter int DW = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_y,
  input  logic [DW-1:0]    in_u,
  input  logic [DW-1:0]    in_v,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_g,
  output logic [DW-1:0]    out_b,
  output logic             out_last,
  output logic [CNT_W-1:0] sat_cnt
);
`ifdef YUV_TO_RGB_STUDIO_RANGE_EN
  localparam int SW = 19;
  localparam logic signed [SW-1:0] KY = 298, YOFF = 16, KR = 409, KGU = 100, KGV = 208, KB = 516;
`else
  localparam int SW = 18;
  localparam logic signed [SW-1:0] KY = 256, YOFF = 0, KR = 359, KGU = 88, KGV = 183, KB = 454;
`endif
  logic rdy1, rdy2, rdy3, v1, v2, v3, l1, l2, cr, cg, cb;
  logic signed [SW-1:0] dy, du, dv, y1, r1, gu1, gv1, b1, r2, g2, b2;
  function automatic logic clip(input logic signed [SW-1:0] x);
    return x[SW-1] || |x[SW-2:DW+8];
  endfunction
  function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] x);
    return x[SW-1] ? '0 : |x[SW-2:DW+8] ? '1 : x[DW+7:8];
  endfunction
  assign rdy3 = !v3 || out_ready;
  assign rdy2 = !v2 || rdy3;
  assign rdy1 = !v1 || rdy2;
  assign in_ready = rdy1;
  assign out_valid = v3;
  assign dy = SW'(in_y) - YOFF;
  assign du = SW'(in_u) - SW'(128);
  assign dv = SW'(in_v) - SW'(128);
  assign cr = clip(r2);
  assign cg = clip(g2);
  assign cb = clip(b2);
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_r <= '0;
      out_g <= '0;
      out_b <= '0;
      out_last <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (rdy1) v1 <= in_valid;
      if (rdy1 && in_valid) begin
        y1 <= KY * dy;
        r1 <= KR * dv;
        gu1 <= KGU * du;
        gv1 <= KGV * dv;
        b1 <= KB * du;
        l1 <= in_last;
      end
      if (rdy2) v2 <= v1;
      if (rdy2 && v1) begin
        r2 <= y1 + r1 + SW'(128);
        g2 <= y1 - gu1 - gv1 + SW'(128);
        b2 <= y1 + b1 + SW'(128);
        l2 <= l1;
      end
      if (rdy3) v3 <= v2;
      if (rdy3 && v2) begin
        out_r <= clamp(r2);
        out_g <= clamp(g2);
        out_b <= clamp(b2);
        out_last <= l2;
        if ((cr || cg || cb) && ~&sat_cnt) sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/yuv_to_rgb.md
Name: yuv_to_rgb

Overview:
- Streaming colour-space converter: full-range BT.601 YUV 4:4:4 in, RGB888 out, one pixel per beat.
- Inverse of the team's RgbToYuv converter; sits on the display/readback side of the same pixel interface.
- 3-stage fixed-point pipeline, valid/ready on both sides, per-stage bubble collapse, saturation event counter.

Parameters:
- DW, 8, component width of Y/U/V and R/G/B; coefficients below are fixed for DW=8.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input pixel valid
- in_ready  output  1  block accepts input this cycle
- in_y  input  DW  luma, 0..255
- in_u  input  DW  Cb, offset 128
- in_v  input  DW  Cr, offset 128
- in_last  input  1  end-of-line tag, passed through unchanged
- out_valid  output  1  output pixel valid
- out_ready  input  1  downstream accepts output
- out_r  output  DW  red
- out_g  output  DW  green
- out_b  output  DW  blue
- out_last  output  1  in_last of the same pixel
- sat_cnt  output  CNT_W  count of output pixels with any clamped component

Behaviour:
- Transfer occurs when valid && ready on the same rising edge.
- Stages S1, S2, S3. v1..v3 are the valid bits. S3 drives out_* directly from registers.
- Stage readiness: rdy3 = !v3 || out_ready; rdy2 = !v2 || rdy3; rdy1 = !v1 || rdy2; in_ready = rdy1. All combinational, no registered ready.
- A stage loads from upstream when its rdy is high. Its valid becomes the upstream valid, so bubbles collapse.
- A stalled stage holds its data and last bit unchanged.
- Latency: 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 pixel/cycle.
- S1: du = U-128, dv = V-128 (signed 9-bit); y8 = Y<<8. Register products 359*dv, 88*du, 183*dv, 454*du.
- S2: register the sums, signed 18-bit:
  - r_s = y8 + 359*dv + 128
  - g_s = y8 - 88*du - 183*dv + 128
  - b_s = y8 + 454*du + 128
- S3: arithmetic shift right by 8, then clamp to 0..255. A result < 0 gives 0; a result > 255 gives 255.
- sat_cnt: +1 on each S3 load where any of the three components clamped.
  - Counts pixels, not components.
  - Saturates at 2^CNT_W-1, no wrap.
- Reset: v1..v3=0, out_valid=0, out_r/g/b=0, out_last=0, sat_cnt=0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - Reset mid-stream drops all in-flight pixels; none is emitted after reset.
  - An in_valid presented during reset is not accepted.
- Simultaneous output drain and input accept on a full pipeline: all stages shift, no loss, no duplication.
- out_* are stable while out_valid && !out_ready.
- in_y/u/v/last values are ignored when in_valid=0.

Optional Feature:
- Macro: YUV_TO_RGB_STUDIO_RANGE_EN.
- Defined: input is studio range and uses these equations:
  - y8 = 298*(Y-16)
  - r_s = y8 + 409*dv + 128
  - g_s = y8 - 100*du - 208*dv + 128
  - b_s = y8 + 516*du + 128
  - Y below 16 yields a negative y8; the clamp handles it.
  - Sum width becomes 19 bits signed. Latency is unchanged.
- Undefined: full-range equations above. No studio logic is synthesised.

Test Plan:
- Single pixel Y=128,U=128,V=128, out_ready=1 -> exactly 3 cycles later out_valid=1 with R=G=B=128; sat_cnt=0.
- Y=100,U=90,V=200 -> R=201,G=62,B=33, no clamp. Y=0,U=128,V=255 -> R=178,G=0,B=0, sat_cnt=1. Y=255,U=255,V=255 -> R=255,G=121,B=255, sat_cnt increments.
- Stream 20 back-to-back pixels with out_ready toggled pseudo-randomly -> order, values and last tags match the model. No drops or duplicates; out_* stable during stalls.
- Hold out_ready=0 while sending pixels -> exactly 3 transfers accepted, then in_ready=0. Raise out_ready for one cycle -> one output and one new input on the same edge.
- Assert rst for 1 cycle with 3 pixels in flight -> out_valid=0, sat_cnt=0, no stale pixel emitted afterwards.
- With YUV_TO_RGB_STUDIO_RANGE_EN, Y=16,U=V=128 -> 0,0,0; Y=235,U=V=128 -> 255,255,255 after clamp (exact 255 from rounding). Y=0 -> 0,0,0, sat_cnt+1.
